spi_master: RTL and testbench



---
 rtl/spi_master.sv | 236 +++++++++++++++++++++++
 tb/tb_spi_master.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// spi_master: SPI initiator for the single-slave register protocol.
// One frame per transaction: ID byte, address byte, data byte, MSB first,
// SCLK idles low. A start/busy/done handshake faces the on-chip side.
// Optional feature (define SPI_WR_VERIFY_EN): every write is followed by an
// automatic read-back of the same address, and a verify_err output flags a
// read-back value that differs from the written data.

module spi_master #(
    parameter int unsigned CLK_DIV   = 8,      // system clocks per SCLK half-period (6..255)
    parameter logic [7:0]  SLAVE_IDW = 8'hFF,  // ID byte for a write frame
    parameter logic [7:0]  SLAVE_IDR = 8'h00,  // ID byte for a read frame
    parameter int unsigned SS_GAP    = 20      // clocks SS stays high before done (>= 17)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       ss,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
`ifdef SPI_WR_VERIFY_EN
    ,
    output logic       verify_err
`endif
);

    // ------------------------------------------------------------------
    // State encoding (kept as plain constants for legacy tool flows)
    // ------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEAD  = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_TRAIL = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;
    localparam logic [2:0] ST_FIN   = 3'd5;

    // One shared down-the-phase counter; 16 bits covers both CLK_DIV and SS_GAP.
    localparam int unsigned CNT_W    = 16;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(SS_GAP - 1);

    // Bit index of the first data-byte bit and of the final frame bit.
    localparam logic [4:0] FIRST_DATA_BIT = 5'd16;
    localparam logic [4:0] LAST_BIT       = 5'd23;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;        // clocks spent in the current phase
    logic [4:0]       bit_cnt;    // frame bit being shifted, 0..23
    logic [23:0]      shift_reg;  // outgoing frame, MSB is on the wire next
    logic [7:0]       rx_shift;   // data-byte bits captured from miso
    logic             rw_q;       // transaction type captured with start

`ifdef SPI_WR_VERIFY_EN
    logic [7:0]       addr_q;      // address reused by the read-back frame
    logic [7:0]       wdata_q;     // written value compared against read-back
    logic             verify_pass; // set while the read-back frame is running
    logic [23:0]      rb_frame;
`endif

    // Frame image loaded when a transaction is accepted.
    logic [7:0]  load_id;
    logic [7:0]  load_data;
    logic [23:0] load_frame;

    // Build the outgoing frame from the live request inputs.
    always_comb begin
        // NOTE: every combinational output gets a value on every path first,
        // otherwise synthesis infers a latch to hold the old value.
        load_id    = SLAVE_IDR;
        load_data  = 8'h00;
        if (rw) begin
            load_id   = SLAVE_IDW;
            load_data = wdata;
        end
        load_frame = {load_id, addr, load_data};
    end

`ifdef SPI_WR_VERIFY_EN
    // Read-back frame reuses the captured address; data byte shifts zeros.
    assign rb_frame = {SLAVE_IDR, addr_q, 8'h00};
`endif

    // Transaction sequencer: FSM, phase counters, shifters and all outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            rx_shift  <= '0;
            rw_q      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rdata     <= 8'h00;
            ss        <= 1'b1;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
`ifdef SPI_WR_VERIFY_EN
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            verify_pass <= 1'b0;
            verify_err  <= 1'b0;
`endif
        end else begin
            // done is a single-cycle pulse unless the GAP exit re-asserts it.
            done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        rw_q      <= rw;
                        shift_reg <= load_frame;
                        mosi      <= load_frame[23];
                        ss        <= 1'b0;
                        sclk      <= 1'b0;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        bit_cnt   <= '0;
                        state     <= ST_LEAD;
`ifdef SPI_WR_VERIFY_EN
                        addr_q      <= addr;
                        wdata_q     <= wdata;
                        verify_pass <= 1'b0;
                        verify_err  <= 1'b0;
`endif
                    end
                end

                // SS low with SCLK low and the first bit already on MOSI.
                ST_LEAD: begin
                    if (cnt == DIV_LAST) begin
                        cnt   <= '0;
                        state <= ST_SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // sclk doubles as the phase flag: 0 = low half, 1 = high half.
                ST_SHIFT: begin
                    if (cnt == DIV_LAST) begin
                        cnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            // End of the high half: capture, fall, advance MOSI.
                            sclk      <= 1'b0;
                            shift_reg <= {shift_reg[22:0], 1'b0};
                            mosi      <= shift_reg[22];
                            if (bit_cnt >= FIRST_DATA_BIT) begin
                                rx_shift <= {rx_shift[6:0], miso};
                            end
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt <= '0;
                                state   <= ST_TRAIL;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Hold SS low one more half-period after the last fall of SCLK.
                ST_TRAIL: begin
                    if (cnt == DIV_LAST) begin
                        cnt   <= '0;
                        ss    <= 1'b1;
                        mosi  <= 1'b0;
                        state <= ST_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // SS high long enough for the slave to finish its DONE handling.
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= '0;
`ifdef SPI_WR_VERIFY_EN
                        if (rw_q && !verify_pass) begin
                            // Chain the read-back frame without a done pulse.
                            verify_pass <= 1'b1;
                            shift_reg   <= rb_frame;
                            mosi        <= rb_frame[23];
                            ss          <= 1'b0;
                            bit_cnt     <= '0;
                            state       <= ST_LEAD;
                        end else begin
                            // The last frame is always a read in this build.
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            rdata <= rx_shift;
                            if (rw_q) begin
                                verify_err <= (rx_shift != wdata_q);
                            end
                            state <= ST_FIN;
                        end
`else
                        done <= 1'b1;
                        busy <= 1'b0;
                        if (!rw_q) begin
                            rdata <= rx_shift;
                        end
                        state <= ST_FIN;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // done is high in this cycle; a new start is accepted next cycle.
                ST_FIN: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed, table-driven bench for spi_master with a
// behavioural register slave on the SPI pins. Also covers the write
// read-back feature when SPI_WR_VERIFY_EN is defined.

`timescale 1ns/1ps

module tb_spi_master;

    localparam int CLK_DIV = 8;
    localparam int SS_GAP  = 20;
    localparam int FRAME_SS_LOW = 50 * CLK_DIV;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       ss;
    logic       sclk;
    logic       mosi;
    logic       miso;
`ifdef SPI_WR_VERIFY_EN
    logic       verify_err;
`endif

    spi_master #(
        .CLK_DIV  (CLK_DIV),
        .SLAVE_IDW(8'hFF),
        .SLAVE_IDR(8'h00),
        .SS_GAP   (SS_GAP)
    ) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .rw    (rw),
        .addr  (addr),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .rdata (rdata),
        .ss    (ss),
        .sclk  (sclk),
        .mosi  (mosi),
        .miso  (miso)
`ifdef SPI_WR_VERIFY_EN
        ,
        .verify_err(verify_err)
`endif
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural slave and pin monitor (all sampling on the falling clock)
    // ------------------------------------------------------------------
    logic [7:0]  mem [256];
    logic [23:0] frames[$];
    logic [23:0] sl_rx;
    logic [7:0]  sl_id, sl_addr, rd_byte;
    int          sl_cnt;
    int          ss_low_cnt, ss_low_meas, rise_meas;
    int          gap_cnt, gap_meas;
    bit          gap_run = 0;
    int          done_cnt = 0;
    int          mosi_err = 0;
    logic        prev_ss = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h11] = 8'h3C;
    end

    always @(negedge clock) begin
        if (done === 1'b1) done_cnt++;
        if (prev_ss === 1'b1 && ss === 1'b0) begin
            sl_cnt = 0; sl_rx = '0; ss_low_cnt = 0; gap_run = 0;
        end
        if (ss === 1'b0) begin
            ss_low_cnt++;
            if (sclk === 1'b1 && prev_sclk === 1'b1 && mosi !== prev_mosi) mosi_err++;
            if (sclk === 1'b1 && prev_sclk === 1'b0) begin
                sl_rx = {sl_rx[22:0], mosi};
                sl_cnt++;
                if (sl_cnt == 16) begin
                    sl_id   = sl_rx[15:8];
                    sl_addr = sl_rx[7:0];
                end
            end
            if (sclk === 1'b0 && prev_sclk === 1'b1) begin
                if (sl_cnt >= 16 && sl_cnt < 24 && sl_id == 8'h00) begin
                    rd_byte = mem[sl_addr];
                    miso = rd_byte[3'(23 - sl_cnt)];
                end else begin
                    miso = 1'b0;
                end
            end
        end
        if (prev_ss === 1'b0 && ss === 1'b1) begin
            ss_low_meas = ss_low_cnt;
            rise_meas   = sl_cnt;
            miso        = 1'b0;
            if (sl_cnt == 24) begin
                frames.push_back(sl_rx);
                // Only addresses below 8'h20 are backed by storage in the slave.
                if (sl_rx[23:16] == 8'hFF && sl_rx[15:8] < 8'h20) mem[sl_rx[15:8]] = sl_rx[7:0];
            end
            gap_run = 1; gap_cnt = 0;
        end
        if (gap_run) begin
            if (done === 1'b1) begin gap_meas = gap_cnt; gap_run = 0; end
            else gap_cnt++;
        end
        prev_ss = ss; prev_sclk = sclk; prev_mosi = mosi;
    end

    // ------------------------------------------------------------------
    // One transaction with the handshake/timing checks common to all.
    // inject_at >= 0 pulses a bogus start that many cycles into the frame.
    // ------------------------------------------------------------------
    task automatic do_txn(input logic t_rw, input logic [7:0] t_addr,
                          input logic [7:0] t_wdata, input int inject_at);
        int dc0, busy_low, exp_frames;
        bit seen;
        exp_frames = 1;
`ifdef SPI_WR_VERIFY_EN
        if (t_rw) exp_frames = 2;
`endif
        frames.delete();
        dc0 = done_cnt;
        rw = t_rw; addr = t_addr; wdata = t_wdata; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        seen = 0; busy_low = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            if (i == inject_at) begin
                start = 1'b1; rw = ~t_rw; addr = 8'h99; wdata = 8'h11;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            if (done === 1'b1) begin
                seen = 1;
                check("busy_low_at_done", busy, 1'b0);
            end else if (busy !== 1'b1) begin
                busy_low++;
            end
        end
        start = 1'b0;
        check("done_seen", seen, 1'b1);
        check("busy_held", busy_low, 0);
        repeat (30) @(negedge clock);
        check("done_pulses", done_cnt - dc0, 1);
        check("frame_count", frames.size(), exp_frames);
        check("ss_low_clocks", ss_low_meas, FRAME_SS_LOW);
        check("sclk_rises", rise_meas, 24);
        check("gap_clocks", gap_meas, SS_GAP);
`ifdef SPI_WR_VERIFY_EN
        if (t_rw && frames.size() == 2) check("readback_frame", frames[1], {8'h00, t_addr, 8'h00});
`endif
    endtask

    typedef struct {
        logic        rw;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [23:0] exp_frame;  // first frame seen by the slave
        logic [7:0]  exp_rdata;  // rdata after done (single-frame build)
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [7:0] exp_rd;
        reset = 1'b1; start = 1'b0; rw = 1'b0; addr = 8'h00; wdata = 8'h00;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_ss", ss, 1'b1);
        check("rst_sclk", sclk, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rdata", rdata, 8'h00);
`ifdef SPI_WR_VERIFY_EN
        check("rst_verify_err", verify_err, 1'b0);
`endif

        vecs[0] = '{1'b1, 8'h10, 8'hA5, 24'hFF10A5, 8'h00};
        vecs[1] = '{1'b0, 8'h11, 8'h77, 24'h001100, 8'h3C};
        vecs[2] = '{1'b1, 8'h12, 8'h5A, 24'hFF125A, 8'h3C};
        vecs[3] = '{1'b0, 8'h13, 8'h00, 24'h001300, 8'h00};
        vecs[4] = '{1'b0, 8'h12, 8'h00, 24'h001200, 8'h5A};

        for (int v = 0; v < 5; v++) begin
            do_txn(vecs[v].rw, vecs[v].addr, vecs[v].wdata, -1);
            check($sformatf("v%0d_frame", v), frames.size() > 0 ? frames[0] : 24'hXXXXXX, vecs[v].exp_frame);
            exp_rd = vecs[v].exp_rdata;
`ifdef SPI_WR_VERIFY_EN
            if (vecs[v].rw) exp_rd = vecs[v].wdata;
`endif
            check($sformatf("v%0d_rdata", v), rdata, exp_rd);
        end

        // Start pulsed during SHIFT bit 5 (LEAD 8 + 5*16 = 88..103) is ignored.
        do_txn(1'b1, 8'h14, 8'h77, 94);
        check("ignored_start_frame", frames.size() > 0 ? frames[0] : 24'hXXXXXX, 24'hFF1477);
`ifdef SPI_WR_VERIFY_EN
        check("ignored_start_rdata", rdata, 8'h77);
`else
        check("ignored_start_rdata", rdata, 8'h5A);
`endif

        // Reset during SHIFT bit 10 (cycles 168..183 of the frame).
        begin
            int dc;
            rw = 1'b1; addr = 8'h15; wdata = 8'h66; start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            repeat (175) @(negedge clock);
            check("pre_reset_ss_low", ss, 1'b0);
            dc = done_cnt;
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
            check("abort_ss", ss, 1'b1);
            check("abort_sclk", sclk, 1'b0);
            check("abort_mosi", mosi, 1'b0);
            check("abort_busy", busy, 1'b0);
            check("abort_done", done, 1'b0);
            check("abort_rdata", rdata, 8'h00);
            repeat (40) @(negedge clock);
            check("abort_no_done", done_cnt - dc, 0);
            check("abort_no_write", mem[8'h15], 8'h00);
        end

        do_txn(1'b1, 8'h15, 8'h66, -1);
        check("post_abort_frame", frames.size() > 0 ? frames[0] : 24'hXXXXXX, 24'hFF1566);
        do_txn(1'b0, 8'h15, 8'h00, -1);
        check("post_abort_read", rdata, 8'h66);

`ifdef SPI_WR_VERIFY_EN
        do_txn(1'b1, 8'h10, 8'h33, -1);
        check("verify_ok_err", verify_err, 1'b0);
        check("verify_ok_rdata", rdata, 8'h33);
        do_txn(1'b1, 8'h20, 8'h44, -1);
        check("verify_bad_err", verify_err, 1'b1);
        check("verify_bad_rdata", rdata, 8'h00);
        repeat (20) @(negedge clock);
        check("verify_err_held", verify_err, 1'b1);
`endif

        check("mosi_stable_while_sclk_high", mosi_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
